pid_channel_sched: RTL

PID_CHANNEL_SCHED -- requirements
Module: pid_channel_sched

---
 rtl/pid_channel_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pid_channel_sched.sv
// pid_channel_sched: time-shares one pid_core among N_CHAN input channels.
// Each channel has a one-deep sample buffer. A round-robin FSM issues one
// buffered sample at a time, waits for the core's done strobe and tags the
// result with the channel index.
// Optional feature macro: SCHED_TIMEOUT_EN adds a WAIT-state watchdog that
// abandons a transaction after TIMEOUT cycles and raises timeout_err_out.
//
//   state    | meaning
//   ST_IDLE  | no transaction; grant the next pending channel round-robin
//   ST_ISSUE | pid_valid_out high for one cycle with the granted sample
//   ST_WAIT  | waiting for pid_done_in (optionally watchdog-limited)
//   ST_DONE  | result_valid_out high for one cycle; last grant recorded
module pid_channel_sched #(
    parameter int N_CHAN  = 8,
    parameter int W_IN    = 18,
    parameter int W_CHAN  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CHAN*W_IN-1:0]   chan_data_in,
    input  logic [N_CHAN-1:0]        chan_valid_in,
    input  logic [N_CHAN-1:0]        lock_en_in,
    input  logic                     ovr_clear_in,
    input  logic                     pid_done_in,
    output logic [W_IN-1:0]          pid_data_out,
    output logic                     pid_valid_out,
    output logic [W_CHAN-1:0]        chan_sel_out,
    output logic                     result_valid_out,
    output logic [W_CHAN-1:0]        result_chan_out,
    output logic [N_CHAN-1:0]        overrun_out,
    output logic                     timeout_err_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t              state_q;
    logic [W_CHAN-1:0]   grant_q;
    logic [W_CHAN-1:0]   last_grant_q;
    logic [W_CHAN-1:0]   next_grant;
    logic [W_CHAN-1:0]   cand;
    logic                found;
    logic [W_IN-1:0]     pid_data_q;
    logic                pid_valid_q;
    logic                result_valid_q;
    logic [W_CHAN-1:0]   result_chan_q;
    logic [W_IN-1:0]     buf_q [N_CHAN];
    logic [N_CHAN-1:0]   pending_q, pending_d;
    logic [N_CHAN-1:0]   overrun_q, overrun_d;
    logic [N_CHAN-1:0]   ovr_set;
    logic [N_CHAN-1:0]   issue_vec;

`ifdef SCHED_TIMEOUT_EN
    localparam int W_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [W_WD-1:0]     wd_cnt_q;
    logic                wd_expire;
    logic                timeout_q;

    assign wd_expire = (state_q == ST_WAIT) && !pid_done_in &&
                       (wd_cnt_q == W_WD'(TIMEOUT - 1));

    // Sticky watchdog flag; a same-cycle expiry wins over the clear.
    always_ff @(posedge clk_in) begin
        if (reset_in) timeout_q <= 1'b0;
        else          timeout_q <= (timeout_q & ~ovr_clear_in) | wd_expire;
    end

    assign timeout_err_out = timeout_q;
`else
    assign timeout_err_out = 1'b0;
`endif

    // Round-robin search for the first pending channel after last_grant.
    always_comb begin
        next_grant = '0;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= N_CHAN; k++) begin
            cand = W_CHAN'((int'(last_grant_q) + k) % N_CHAN);
            if (!found && pending_q[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    // Pending/overrun next state; the channel being issued may be re-strobed
    // without counting as an overrun, and its new sample stays pending.
    always_comb begin
        pending_d = pending_q;
        ovr_set   = '0;
        issue_vec = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            issue_vec[i] = (state_q == ST_ISSUE) && (grant_q == W_CHAN'(i));
            if (!lock_en_in[i]) begin
                pending_d[i] = 1'b0;
            end else if (chan_valid_in[i]) begin
                pending_d[i] = 1'b1;
                ovr_set[i]   = pending_q[i] && !issue_vec[i];
            end else if (issue_vec[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        overrun_d = (overrun_q & ~{N_CHAN{ovr_clear_in}}) | ovr_set;
    end

    // Per-channel sample buffers; only locked channels accept samples.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (lock_en_in[i] && chan_valid_in[i])
                buf_q[i] <= chan_data_in[i*W_IN +: W_IN];
        end
    end

    // Pending bits and sticky overrun flags.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Scheduler FSM with registered strobes, grant and result tag.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_grant_q   <= W_CHAN'(N_CHAN - 1);
            pid_data_q     <= '0;
            pid_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_chan_q  <= '0;
`ifdef SCHED_TIMEOUT_EN
            wd_cnt_q       <= '0;
`endif
        end else begin
            pid_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        grant_q     <= next_grant;
                        pid_data_q  <= buf_q[next_grant];
                        pid_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
`ifdef SCHED_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    if (pid_done_in) begin
                        result_valid_q <= 1'b1;
                        result_chan_q  <= grant_q;
                        state_q        <= ST_DONE;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (wd_expire) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pid_data_out     = pid_data_q;
    assign pid_valid_out    = pid_valid_q;
    assign chan_sel_out     = grant_q;
    assign result_valid_out = result_valid_q;
    assign result_chan_out  = result_chan_q;
    assign overrun_out      = overrun_q;

endmodule
